// File: rtl/log2_lut_sched.sv
// Purpose : round-robin share of the two Log2 LUT read ports among NREQ requesters,
//           capturing each lookup into a per-requester response register (valid/ready).
// Ports   : clock/reset (sync, active-high); req_valid/req_index/req_ready (request side);
//           resp_valid/resp_data/resp_ready (response side); lut_index0/1, lut_out0/1 (LUT);
//           perf_lookups/perf_stalls (counters, built only with LOG2_LUT_SCHED_PERF_EN).
// Latency : grant in cycle N -> resp_valid in cycle N+1. Backpressure: an unconsumed
//           response blocks only its own requester.
module log2_lut_sched #(
  parameter int WIDTH = 16,
  parameter int BP    = 8,
  parameter int DEPTH = 32,
  parameter int NREQ  = 4,
  localparam int IW   = $clog2(DEPTH),
  localparam int PW   = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*IW-1:0]      req_index,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [NREQ*WIDTH-1:0]   resp_data,
  input  logic [NREQ-1:0]         resp_ready,
  output logic [IW-1:0]           lut_index0,
  output logic [IW-1:0]           lut_index1,
  input  logic [WIDTH-1:0]        lut_out0,
  input  logic [WIDTH-1:0]        lut_out1,
  output logic [31:0]             perf_lookups,
  output logic [31:0]             perf_stalls
);

  // BP only describes the data format; it is never applied to the data. A binary
  // point wider than the word collapses the slice width and breaks elaboration.
  localparam int DW = (BP <= WIDTH) ? WIDTH : 0;

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]       resp_valid_q, resp_valid_d;
  logic [NREQ*WIDTH-1:0] resp_data_q, resp_data_d;

  logic [NREQ-1:0] elig;
  logic            gnt0_vld, gnt1_vld;
  logic [PW-1:0]   gnt0_id, gnt1_id;

  // Requester at position k in the round-robin order starting at p.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] g);
    return (int'(g) == NREQ - 1) ? '0 : PW'(int'(g) + 1);
  endfunction

  // Arbitration and LUT port drive. A response being consumed this cycle frees its
  // slot, so that requester may be granted again in the same cycle.
  always_comb begin
    elig      = req_valid & ~(resp_valid_q & ~resp_ready);
    gnt0_vld  = 1'b0;
    gnt1_vld  = 1'b0;
    gnt0_id   = '0;
    gnt1_id   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!reset && elig[rr_idx(rr_ptr_q, k)]) begin
        if (!gnt0_vld) begin
          gnt0_vld = 1'b1;
          gnt0_id  = rr_idx(rr_ptr_q, k);
        end else if (!gnt1_vld) begin
          gnt1_vld = 1'b1;
          gnt1_id  = rr_idx(rr_ptr_q, k);
        end
      end
    end

    req_ready = '0;
    if (gnt0_vld) req_ready[gnt0_id] = 1'b1;
    if (gnt1_vld) req_ready[gnt1_id] = 1'b1;

    lut_index0 = gnt0_vld ? req_index[int'(gnt0_id)*IW +: IW] : '0;
    lut_index1 = gnt1_vld ? req_index[int'(gnt1_id)*IW +: IW] : '0;
  end

  // Response registers and pointer. A grant overrides a same-cycle release.
  always_comb begin
    resp_valid_d = resp_valid_q & ~resp_ready;
    resp_data_d  = resp_data_q;
    rr_ptr_d     = rr_ptr_q;
    if (gnt0_vld) begin
      resp_valid_d[gnt0_id]              = 1'b1;
      resp_data_d[int'(gnt0_id)*DW +: DW] = lut_out0;
    end
    if (gnt1_vld) begin
      resp_valid_d[gnt1_id]              = 1'b1;
      resp_data_d[int'(gnt1_id)*DW +: DW] = lut_out1;
    end
    // Pointer moves past the last requester served in priority order.
    if (gnt1_vld)      rr_ptr_d = rr_next(gnt1_id);
    else if (gnt0_vld) rr_ptr_d = rr_next(gnt0_id);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

`ifdef LOG2_LUT_SCHED_PERF_EN
  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;
  logic [32:0] lookups_sum, stalls_sum;
  logic [3:0]  n_stall;

  always_comb begin
    n_stall = '0;
    for (int i = 0; i < NREQ; i++) begin
      n_stall = n_stall + {3'b000, req_valid[i] & ~req_ready[i]};
    end
    lookups_sum = {1'b0, perf_lookups_q} + {31'b0, gnt0_vld} + {31'b0, gnt1_vld};
    stalls_sum  = {1'b0, perf_stalls_q} + {29'b0, n_stall};
    // Saturate rather than wrap.
    perf_lookups_d = lookups_sum[32] ? 32'hFFFF_FFFF : lookups_sum[31:0];
    perf_stalls_d  = stalls_sum[32]  ? 32'hFFFF_FFFF : stalls_sum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_lookups_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_lookups_q <= perf_lookups_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_lookups = perf_lookups_q;
  assign perf_stalls  = perf_stalls_q;
`else
  assign perf_lookups = '0;
  assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_log2_lut_sched.sv
// Bench for log2_lut_sched: NREQ=4, DEPTH=32, WIDTH=16. A behavioural model tracks
// held responses, the round-robin start and the counters; directed steps from the
// block's intended use are followed by randomized traffic.
module tb_log2_lut_sched;
  localparam int NREQ = 4;
  localparam int IW = 5;
  localparam int W = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*IW-1:0] req_index;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ*W-1:0] resp_data;
  logic [NREQ-1:0]   resp_ready;
  logic [IW-1:0]     lut_index0, lut_index1;
  logic [W-1:0]      lut_out0, lut_out1;
  logic [31:0]       perf_lookups, perf_stalls;

  logic [W-1:0] lut_mem [32];

  log2_lut_sched #(.WIDTH(16), .BP(8), .DEPTH(32), .NREQ(4)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .lut_index0(lut_index0), .lut_index1(lut_index1),
    .lut_out0(lut_out0), .lut_out1(lut_out1),
    .perf_lookups(perf_lookups), .perf_stalls(perf_stalls)
  );

  always #5 clock = ~clock;

  // Combinational LUT stand-in.
  assign lut_out0 = lut_mem[lut_index0];
  assign lut_out1 = lut_mem[lut_index1];

  int errors = 0;
  int checks = 0;

  // Model state.
  bit          m_known = 0;
  bit          m_valid [NREQ];
  logic [W-1:0] m_data [NREQ];
  int          m_ptr;
  longint      m_lookups, m_stalls;
  int          g_list [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i] = 0;
      m_data[i]  = '0;
    end
    m_ptr = 0;
    m_lookups = 0;
    m_stalls = 0;
  endtask

  // One clock: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic rst, input logic [3:0] v, input logic [19:0] idx,
                      input logic [3:0] rr);
    logic [3:0]  exp_ready;
    logic [4:0]  exp_li0, exp_li1;
    logic [3:0]  exp_valid;
    logic [63:0] exp_data;
    longint      exp_pl, exp_ps;
    int          n_stall;
    @(negedge clock);
    reset = rst; req_valid = v; req_index = idx; resp_ready = rr;
    #1;
    g_list.delete();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (!rst && v[i] && !(m_valid[i] && !rr[i]) && g_list.size() < 2) g_list.push_back(i);
    end
    exp_ready = '0;
    foreach (g_list[j]) exp_ready[g_list[j]] = 1'b1;
    exp_li0 = (g_list.size() > 0) ? idx[g_list[0]*IW +: IW] : 5'd0;
    exp_li1 = (g_list.size() > 1) ? idx[g_list[1]*IW +: IW] : 5'd0;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("lut_index0", 64'(lut_index0), 64'(exp_li0));
    chk("lut_index1", 64'(lut_index1), 64'(exp_li1));
    if (m_known) begin
      for (int i = 0; i < NREQ; i++) begin
        exp_valid[i] = m_valid[i];
        exp_data[i*W +: W] = m_data[i];
      end
      chk("resp_valid", 64'(resp_valid), 64'(exp_valid));
      chk("resp_data", 64'(resp_data), exp_data);
`ifdef LOG2_LUT_SCHED_PERF_EN
      exp_pl = m_lookups; exp_ps = m_stalls;
`else
      exp_pl = 0; exp_ps = 0;
`endif
      chk("perf_lookups", 64'(perf_lookups), 64'(exp_pl));
      chk("perf_stalls", 64'(perf_stalls), 64'(exp_ps));
    end
    @(posedge clock);
    if (rst) begin
      model_reset();
      m_known = 1;
    end else begin
      n_stall = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (v[i] && !exp_ready[i]) n_stall++;
        if (exp_ready[i]) begin
          m_valid[i] = 1;
          m_data[i]  = lut_mem[idx[i*IW +: IW]];
        end else if (m_valid[i] && rr[i]) begin
          m_valid[i] = 0;
        end
      end
      if (g_list.size() > 0) m_ptr = (g_list[g_list.size()-1] + 1) % NREQ;
      m_lookups = m_lookups + g_list.size();
      m_stalls  = m_stalls + n_stall;
      if (m_lookups > 64'hFFFF_FFFF) m_lookups = 64'hFFFF_FFFF;
      if (m_stalls  > 64'hFFFF_FFFF) m_stalls  = 64'hFFFF_FFFF;
    end
    #2;
  endtask

  initial begin
    // log2 table in 8.8 fixed point; entry 0 is the -100 floor.
    lut_mem[0] = 16'h9C00;
    for (int i = 1; i < 32; i++)
      lut_mem[i] = 16'(int'($floor($ln(real'(i)) / $ln(2.0) * 256.0 + 1.0e-6)));
    model_reset();
    reset = 1; req_valid = '0; req_index = '0; resp_ready = '0;

    step(1, 4'b0000, 20'd0, 4'b0000);
    step(1, 4'b1111, 20'hFFFFF, 4'b1111);

    // Single request, index 8.
    step(0, 4'b0001, {15'd0, 5'd8}, 4'b1111);
    step(0, 4'b0000, 20'd0, 4'b1111);
    chk("single_data", 64'(resp_data[15:0]), 64'h0300);

    // All four requesting from pointer 0.
    step(1, 4'b0000, 20'd0, 4'b1111);
    step(0, 4'b1111, {5'd16, 5'd8, 5'd4, 5'd2}, 4'b1111);
    step(0, 4'b1111, {5'd16, 5'd8, 5'd4, 5'd2}, 4'b1111);
    step(0, 4'b0000, 20'd0, 4'b1111);
    chk("all4_data", 64'(resp_data), 64'h0400_0300_0200_0100);

    // Requester 1 stalled by its own unconsumed response.
    for (int c = 0; c < 5; c++) step(0, 4'b0111, {5'd0, 5'd7, 5'd6, 5'd5}, 4'b1101);
    step(0, 4'b0111, {5'd0, 5'd9, 5'd6, 5'd5}, 4'b1111);

    // Back-to-back stream on requester 0.
    step(1, 4'b0000, 20'd0, 4'b1111);
    step(0, 4'b0001, {15'd0, 5'd1}, 4'b1111);
    step(0, 4'b0001, {15'd0, 5'd2}, 4'b1111);
    step(0, 4'b0001, {15'd0, 5'd3}, 4'b1111);
    chk("stream_data", 64'(resp_data[15:0]), 64'h0195);
    step(0, 4'b0000, 20'd0, 4'b0000);

    // Index 0 floor, then reset right after a grant.
    step(0, 4'b0001, 20'd0, 4'b1111);
    chk("idx0_data", 64'(resp_data[15:0]), 64'h9C00);
    step(0, 4'b0010, {10'd0, 5'd4, 5'd0}, 4'b0000);
    step(1, 4'b0000, 20'd0, 4'b0000);
    for (int c = 0; c < 3; c++) step(0, 4'b0000, 20'd0, 4'b0000);
    chk("post_reset_valid", 64'(resp_valid), 64'h0);

    // Counters: three requesters for one cycle.
    step(1, 4'b0000, 20'd0, 4'b1111);
    step(0, 4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, 4'b1111);
`ifdef LOG2_LUT_SCHED_PERF_EN
    chk("perf_lookups_3req", 64'(perf_lookups), 64'd2);
    chk("perf_stalls_3req", 64'(perf_stalls), 64'd1);
`else
    chk("perf_lookups_3req", 64'(perf_lookups), 64'd0);
    chk("perf_stalls_3req", 64'(perf_stalls), 64'd0);
`endif

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [3:0] rr;
      rr = 4'($urandom) | 4'($urandom);
      step(($urandom_range(0, 39) == 0), 4'($urandom), 20'($urandom), rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/log2_lut_sched.md
# log2_lut_sched

Round-robin scheduler that shares the two combinational read ports of the Log2 lookup table among `NREQ` requesters in the cepstrum log-magnitude stage. It grants up to two lookups per cycle and drives the LUT indices. It captures the LUT outputs into per-requester response registers and holds each response under a valid/ready handshake until it is consumed. The block sits between the magnitude/normalisation units (requesters) and the single `Log2LUT` instance.

## Interface
Parameters:
- `WIDTH`, 16, LUT data width; fixed-point with `BP` fractional bits.
- `BP`, 8, binary point of LUT data; informational only, no arithmetic on data.
- `DEPTH`, 32, LUT entries; must be a power of two. `IW = $clog2(DEPTH)`.
- `NREQ`, 4, number of requesters, 2..8. `PW = $clog2(NREQ)`.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NREQ  bit i: requester i presents a lookup.
- `req_index`  in  NREQ*IW  requester i index at bits [i*IW +: IW].
- `req_ready`  out  NREQ  bit i: requester i's lookup issued this cycle (combinational).
- `resp_valid`  out  NREQ  registered; bit i: response for requester i held.
- `resp_data`  out  NREQ*WIDTH  registered LUT value for requester i at bits [i*WIDTH +: WIDTH].
- `resp_ready`  in  NREQ  bit i: requester i consumes its response.
- `lut_index0`, `lut_index1`  out  IW  driven to the LUT read ports (combinational).
- `lut_out0`, `lut_out1`  in  WIDTH  LUT read data, combinational from the indices.
- `perf_lookups`  out  32  issued-lookup counter (see Configuration).
- `perf_stalls`  out  32  stalled-request counter (see Configuration).

## Operation
- Eligibility: `elig[i] = req_valid[i] && !(resp_valid[i] && !resp_ready[i])`. A requester whose held response is consumed this cycle is eligible again.
- Arbitration: scan i = `rr_ptr`, `rr_ptr+1`, … mod NREQ. The first eligible requester gets port 0. The second gets port 1. All others are not granted.
- `req_ready[i]` = 1 only for granted requesters. It depends on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- Port drive: `lut_index0`/`lut_index1` = granted requester's `req_index`, else 0.
- Capture on the edge: a grant on port k loads `resp_data[i] <= lut_outk` and sets `resp_valid[i] <= 1`.
- Release: if `resp_valid[i] && resp_ready[i]` and there is no new grant for i, `resp_valid[i] <= 0`. `resp_data[i]` holds its value.
- Simultaneous consume and grant for the same i: new data loads and `resp_valid[i]` stays 1. This gives one lookup per cycle per requester.
- Pointer: if any grant, `rr_ptr <= (highest-priority-order last granted index + 1) mod NREQ`; else unchanged.
- Data is passed through unmodified. Index 0 returns whatever the LUT holds (the -100 floor).

## Timing
- Reset (synchronous, wins over all updates): `rr_ptr=0`, `resp_valid=0`, `resp_data=0`, `perf_*=0`.
- Outputs during the reset cycle: `req_ready=0`, `lut_index*=0`.
- Latency: request granted in cycle N → `resp_valid` high in cycle N+1 with data.
- Throughput: 2 lookups/cycle aggregate; 1/cycle per requester with `resp_ready` held high.
- Backpressure: a response that is not consumed blocks only its own requester. Other requesters are unaffected.
- Reset mid-operation: pending responses are discarded and no response appears after reset deasserts.

## Configuration
- `LOG2_LUT_SCHED_PERF_EN` defined:
  - `perf_lookups` adds the number of grants per cycle (0–2).
  - `perf_stalls` adds the count of `req_valid[i] && !req_ready[i]` per cycle.
  - Both counters saturate at 0xFFFFFFFF.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Single request: reset, then `req_valid=0001`, index 8 → `req_ready=0001`, `lut_index0=8`, `lut_index1=0`. Next cycle `resp_valid=0001`, `resp_data[0]=0x0300`.
- All four requesting (indices 2,4,8,16), `rr_ptr=0`, `resp_ready=1111`:
  - cycle 0: grants 0,1;
  - cycle 1: grants 2,3 → `resp_data` = 0x0100, 0x0200, 0x0300, 0x0400;
  - `rr_ptr` sequence 0→2→0.
- Backpressure: requester 1 with `resp_ready[1]=0` and `req_valid[1]=1` held → no further grant to 1. Requesters 0 and 2 keep getting grants. Raising `resp_ready[1]` regrants 1 the same cycle.
- Consume+grant collision: requester 0 streams indices 1,2,3 with `resp_ready=1` → `resp_valid[0]` stays 1 for 3 cycles with data 0x0000, 0x0100, 0x0195.
- Index 0 and reset mid-flight:
  - index 0 → `resp_data=0x9C00`;
  - assert `reset` the cycle after a grant → `resp_valid=0` and stays 0.
- With `LOG2_LUT_SCHED_PERF_EN`: 3 requesters valid for 1 cycle → `perf_lookups=2`, `perf_stalls=1`. Without the macro both read 0.
